// File: rtl/imem_loader_ram_if.sv
// Bus bundle for imem_loader_ram: boot-load stream plus CPU byte-addressed port.
// The host/testbench takes the master modport; the memory takes the slave modport.
interface imem_loader_ram_if #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              LD_START;
  logic              LD_VALID;
  logic [31:0]       LD_DATA;
  logic              LD_LAST;
  logic              LD_READY;
  logic              LD_DONE;
  logic [CW-1:0]     LD_COUNT;
  logic              BUSY;
  logic [ADDR_W-1:0] ADDR;
  logic              WE;
  logic [1:0]        SIZE;
  logic [31:0]       W_DATA;
  logic [31:0]       R_DATA;
  logic              MISALIGN;

  modport master (
    output LD_START, LD_VALID, LD_DATA, LD_LAST, ADDR, WE, SIZE, W_DATA,
    input  LD_READY, LD_DONE, LD_COUNT, BUSY, R_DATA, MISALIGN
  );

  modport slave (
    input  LD_START, LD_VALID, LD_DATA, LD_LAST, ADDR, WE, SIZE, W_DATA,
    output LD_READY, LD_DONE, LD_COUNT, BUSY, R_DATA, MISALIGN
  );
endinterface

// File: rtl/imem_loader_ram.sv
// Word-organised MIPS program/data memory with a streaming boot loader and
// byte/halfword/word CPU writes guarded by alignment and range checks.
module imem_loader_ram #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input logic              CLK,
  input logic              RST,
  imem_loader_ram_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_next;
  logic [CW-1:0] ptr, count;
  logic [31:0]   mem [DEPTH];
  logic          accept, busy, in_range, misalign, cpu_we;
  logic [IW-1:0] idx;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.LD_READY = 1'b0;
    bus.LD_DONE  = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: if (bus.LD_START) state_next = LOAD;
      LOAD: begin
        bus.LD_READY = 1'b1;
        busy         = 1'b1;
        if (accept && (bus.LD_LAST || ptr == CW'(DEPTH - 1))) state_next = DONE;
      end
      DONE: begin
        bus.LD_DONE = 1'b1;
        busy        = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept       = bus.LD_VALID && (state == LOAD);
  assign bus.BUSY     = busy;
  assign bus.LD_COUNT = count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr   <= '0;
      count <= '0;
    end else if (state == IDLE && bus.LD_START) begin
      ptr   <= '0;
      count <= '0;
    end else if (accept) begin
      ptr   <= ptr + 1'b1;
      count <= ptr + 1'b1;
    end
  end

  // Any address bit above the word index makes the access out of range.
  assign in_range = (bus.ADDR >> (IW + 2)) == '0;
  assign idx      = bus.ADDR[IW+1:2];

  always_comb begin
    misalign = 1'b0;
    case (bus.SIZE)
      2'b01:   misalign = bus.ADDR[0];
      2'b10:   misalign = (bus.ADDR[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
  assign bus.MISALIGN = misalign;

  always_comb begin
    lane_en   = '0;
    lane_data = '0;
    case (bus.SIZE)
      2'b00: begin
        lane_en   = 4'b0001 << bus.ADDR[1:0];
        lane_data = {4{bus.W_DATA[7:0]}};
      end
      2'b01: begin
        lane_en   = bus.ADDR[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.W_DATA[15:0]}};
      end
      2'b10: begin
        lane_en   = 4'b1111;
        lane_data = bus.W_DATA;
      end
      default: begin
        lane_en   = '0;
        lane_data = '0;
      end
    endcase
  end

  assign cpu_we = bus.WE && !busy && !RST && !misalign && (bus.SIZE != 2'b11) && in_range;

  // Array is deliberately not reset so a loaded image survives RST.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[ptr[IW-1:0]] <= bus.LD_DATA;
    end else if (cpu_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  assign bus.R_DATA = (RST || busy || !in_range) ? '0 : mem[idx];
endmodule

// File: tb/tb_imem_loader_ram.sv
// Self-checking bench for imem_loader_ram: boot loads, CPU lane writes,
// alignment/range faults, busy lockout and asynchronous reset abort.
module tb_imem_loader_ram;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_ram_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();
  imem_loader_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] load_data [32];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    e = sb.pop_front();
    check_eq(e.tag, bus.R_DATA, e.val);
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    return (w < DEPTH) ? model[w] : 32'h0;
  endfunction

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.WE   = 1'b0;
    bus.ADDR = a;
    bus.SIZE = 2'b10;
    sb.push_back('{tag, exp});
    #1 sb_compare();
  endtask

  // R_DATA must still show the pre-write word while the write is pending.
  task automatic cpu_wr(input string tag, input logic [31:0] a, input logic [1:0] size,
                        input logic [31:0] data, input logic exp_mis, input bit do_write);
    int unsigned w;
    int off;
    @(negedge clk);
    bus.WE     = 1'b1;
    bus.ADDR   = a;
    bus.SIZE   = size;
    bus.W_DATA = data;
    sb.push_back('{{tag, "_old"}, model_rd(a)});
    #1;
    check_eq({tag, "_mis"}, 32'(bus.MISALIGN), 32'(exp_mis));
    sb_compare();
    if (do_write) begin
      w = a >> 2;
      case (size)
        2'b00: begin off = 8 * int'(a[1:0]); model[w][off +: 8] = data[7:0]; end
        2'b01: begin off = 16 * int'(a[1]); model[w][off +: 16] = data[15:0]; end
        default: model[w] = data;
      endcase
    end
  endtask

  task automatic do_load(input string tag, input int n, input int last_idx, input int gap_after,
                         input int budget, input int exp_acc);
    int sent = 0, acc = 0, cyc = 0, tail = 0;
    int done_cnt = 0, done_cyc = -1, last_acc = -1, busy_bad = 0, rdy_after = 0;
    bit gap_done = 1'b0;
    @(negedge clk);
    bus.WE       = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_START = 1'b1;
    @(negedge clk);
    bus.LD_START = 1'b0;
    while (cyc < budget && tail < 3) begin
      if (sent >= n) begin
        bus.LD_VALID = 1'b0;
        bus.LD_LAST  = 1'b0;
        tail++;
      end else if (!gap_done && gap_after >= 0 && sent == gap_after + 1) begin
        bus.LD_VALID = 1'b0;
        gap_done     = 1'b1;
      end else begin
        bus.LD_VALID = 1'b1;
        bus.LD_DATA  = load_data[sent];
        bus.LD_LAST  = (sent == last_idx);
      end
      #1;
      if (bus.LD_DONE) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt == 0 && !bus.BUSY) busy_bad++;
      if (done_cnt > 0 && bus.LD_READY) rdy_after++;
      if (bus.LD_VALID && bus.LD_READY) begin
        if (acc < DEPTH) model[acc] = bus.LD_DATA;
        acc++;
        sent++;
        last_acc = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
    check_eq({tag, "_accepted"}, acc, exp_acc);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_done_timing"}, done_cyc, last_acc + 1);
    check_eq({tag, "_busy_gaps"}, busy_bad, 0);
    check_eq({tag, "_ready_after_done"}, rdy_after, 0);
    check_eq({tag, "_count"}, 32'(bus.LD_COUNT), exp_acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.LD_START = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_DATA  = '0;
    bus.LD_LAST  = 1'b0;
    bus.ADDR     = '0;
    bus.WE       = 1'b0;
    bus.SIZE     = 2'b10;
    bus.W_DATA   = '0;

    #12;
    check_eq("rst_ready", 32'(bus.LD_READY), 0);
    check_eq("rst_done", 32'(bus.LD_DONE), 0);
    check_eq("rst_busy", 32'(bus.BUSY), 0);
    check_eq("rst_count", 32'(bus.LD_COUNT), 0);
    check_eq("rst_rdata", bus.R_DATA, 0);
    @(negedge clk);
    rst = 1'b0;

    // Short program with LD_LAST and a wait cycle after the second word.
    load_data[0] = 32'h20080005;
    load_data[1] = 32'h20090003;
    load_data[2] = 32'h01095020;
    load_data[3] = 32'hAC0A0000;
    do_load("load4", 4, 3, 1, 20, 4);
    rd("load4_w2", 32'h8, 32'h01095020);

    // Overflow: 20 words offered, only DEPTH accepted.
    for (int i = 0; i < 20; i++) load_data[i] = 32'hD00D0000 + i;
    do_load("ovf", 20, -1, -1, 30, DEPTH);
    rd("ovf_w15", 32'h3C, 32'hD00D000F);
    rd("ovf_w0", 32'h0, model_rd(32'h0));

    // Lane writes.
    cpu_wr("wr_word", 32'h10, 2'b10, 32'h11223344, 1'b0, 1'b1);
    rd("wr_word_rd", 32'h10, 32'h11223344);
    cpu_wr("wr_byte", 32'h12, 2'b00, 32'h000000AA, 1'b0, 1'b1);
    cpu_wr("wr_half", 32'h10, 2'b01, 32'h0000BEEF, 1'b0, 1'b1);
    rd("lanes_rd", 32'h10, 32'h11AABEEF);
    cpu_wr("wr_byte3", 32'h17, 2'b00, 32'h5A5A5A77, 1'b0, 1'b1);
    rd("byte3_rd", 32'h14, model_rd(32'h14));

    // Faulting writes leave memory untouched.
    cpu_wr("mis_word", 32'h11, 2'b10, 32'hFFFFFFFF, 1'b1, 1'b0);
    cpu_wr("mis_half", 32'h13, 2'b01, 32'hFFFFFFFF, 1'b1, 1'b0);
    cpu_wr("rsv_size", 32'h10, 2'b11, 32'hFFFFFFFF, 1'b0, 1'b0);
    rd("mis_unchanged", 32'h10, 32'h11AABEEF);
    cpu_wr("oor_wr", DEPTH * 4, 2'b10, 32'hCAFEBABE, 1'b0, 1'b0);
    rd("oor_rd", DEPTH * 4, 32'h0);
    rd("oor_alias", 32'h0, model_rd(32'h0));

    // CPU write while the loader owns the memory.
    @(negedge clk);
    bus.WE = 1'b0;
    bus.LD_START = 1'b1;
    @(negedge clk);
    bus.LD_START = 1'b0;
    bus.WE       = 1'b1;
    bus.ADDR     = 32'h10;
    bus.SIZE     = 2'b10;
    bus.W_DATA   = 32'hDEADBEEF;
    #1;
    check_eq("busy_rdata", bus.R_DATA, 0);
    check_eq("busy_flag", 32'(bus.BUSY), 1);
    @(negedge clk);
    bus.WE       = 1'b0;
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = 32'h0BADF00D;
    bus.LD_LAST  = 1'b1;
    #1 check_eq("busy_ready", 32'(bus.LD_READY), 1);
    model[0] = 32'h0BADF00D;
    @(negedge clk);
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
    #1 check_eq("busy_done", 32'(bus.LD_DONE), 1);
    rd("busy_dropped", 32'h10, 32'h11AABEEF);
    rd("busy_w0", 32'h0, 32'h0BADF00D);

    // Asynchronous reset two words into a load.
    @(negedge clk);
    bus.LD_START = 1'b1;
    @(negedge clk);
    bus.LD_START = 1'b0;
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = 32'hA1A1A1A1;
    @(negedge clk);
    bus.LD_DATA  = 32'hA2A2A2A2;
    @(negedge clk);
    bus.LD_VALID = 1'b0;
    #1;
    check_eq("abort_pre_count", 32'(bus.LD_COUNT), 2);
    check_eq("abort_pre_busy", 32'(bus.BUSY), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(bus.BUSY), 0);
    check_eq("abort_ready", 32'(bus.LD_READY), 0);
    check_eq("abort_count", 32'(bus.LD_COUNT), 0);
    model[0] = 32'hA1A1A1A1;
    model[1] = 32'hA2A2A2A2;
    @(negedge clk);
    rst = 1'b0;
    rd("abort_w0", 32'h0, 32'hA1A1A1A1);
    rd("abort_w1", 32'h4, 32'hA2A2A2A2);

    load_data[0] = 32'hC0C00001;
    do_load("reload", 1, 0, -1, 10, 1);
    rd("reload_w0", 32'h0, 32'hC0C00001);
    rd("reload_w1", 32'h4, 32'hA2A2A2A2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader_ram.md
Name: imem_loader_ram

Overview:
- Parametrised word-organised program/data memory for the single-clock MIPS.
- Adds a streaming boot-load port: a valid/ready word stream with an auto-incrementing address and a load FSM.
- Adds byte/halfword/word CPU writes with alignment checking.
- Replaces file-only initialisation: the testbench or host can reload the program at run time, then release the CPU.

Parameters:
- DEPTH, 128, number of 32-bit words (power of two, 4..4096).
- ADDR_W, 32, width of the CPU byte address.
- CW, $clog2(DEPTH)+1, width of the load counter (derived, not overridden).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- LD_START  in  1  request a new load starting at word 0.
- LD_VALID  in  1  LD_DATA holds a valid word.
- LD_DATA  in  32  word to load.
- LD_LAST  in  1  qualifies the final word of the stream.
- LD_READY  out  1  loader accepts a word this cycle.
- LD_DONE  out  1  one-cycle pulse when a load finishes.
- LD_COUNT  out  CW  words written by the most recent load.
- BUSY  out  1  load in progress; CPU port is locked out.
- ADDR  in  ADDR_W  CPU byte address.
- WE  in  1  CPU write enable.
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- W_DATA  in  32  CPU write data, right-justified for byte/half.
- R_DATA  out  32  word read at ADDR.
- MISALIGN  out  1  combinational alignment fault for the current access.

Behaviour:
- Reset (async, while RST=1): state=IDLE, load pointer=0, LD_COUNT=0, LD_READY=0, LD_DONE=0, BUSY=0, R_DATA=0. The memory array is not cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on LD_START=1.
- LOAD -> DONE on an accepted word with LD_LAST=1, or on an accepted word at pointer DEPTH-1.
- DONE -> IDLE unconditionally after one cycle.
- In LOAD: LD_READY=1 and BUSY=1.
- Transfer occurs when LD_VALID & LD_READY at a rising edge: mem[ptr]<=LD_DATA, ptr<=ptr+1, LD_COUNT<=ptr+1.
- Entering LOAD: ptr and LD_COUNT are cleared to 0.
- LD_START while in LOAD or DONE is ignored.
- In DONE: LD_DONE=1, BUSY=1, LD_READY=0. Words offered in this cycle are not accepted.
- Overflow: the stream can never write beyond word DEPTH-1. Excess words are left unaccepted (LD_READY=0 after the FSM leaves LOAD).
- Reset during LOAD: aborts to IDLE. Words already written remain in memory; LD_COUNT=0.
- CPU writes occur on a rising edge when WE=1, BUSY=0, RST=0, MISALIGN=0, SIZE!=11, and the word index is in range.
- Word index = ADDR>>2. In range means index < DEPTH; upper address bits beyond the index must be zero.
- Byte write: lane ADDR[1:0] <= W_DATA[7:0]; the other lanes are unchanged.
- Halfword write: lanes {ADDR[1],1'b1 : ADDR[1],1'b0} <= W_DATA[15:0].
- Word write: whole word <= W_DATA.
- MISALIGN=1 when WE or read is attempted with SIZE=01 and ADDR[0]=1, or SIZE=10 and ADDR[1:0]!=0. It is 0 for SIZE=00 and SIZE=11.
- A misaligned, reserved-size, out-of-range or BUSY write is dropped silently; memory is unchanged.
- R_DATA is combinational: the full aligned word mem[ADDR>>2].
- R_DATA is forced to 0 when RST=1, BUSY=1, or the index is out of range.
- Read-during-write to the same word returns the old data until the edge; new data appears the same cycle after the edge.
- LD_COUNT holds its value until the next LD_START or reset.

Test Plan:
- Load 4 words (0x20080005, 0x20090003, 0x01095020, 0xAC0A0000) with LD_LAST on word 4, one wait cycle inserted (LD_VALID=0) after word 2 -> LD_DONE pulses exactly one cycle after word 4; LD_COUNT=4; BUSY=1 throughout; after DONE, R_DATA at ADDR 0x8 = 0x01095020.
- Load without LD_LAST, DEPTH=16, offer 20 words -> exactly 16 accepted; LD_READY=0 from the DONE cycle; LD_COUNT=16; word 15 holds the 16th datum.
- CPU writes word 0x11223344 at 0x10, then SIZE=00 at 0x12 with data 0xAA, then SIZE=01 at 0x10 with data 0xBEEF -> R_DATA at 0x10 = 0x11AABEEF.
- Misaligned cases: SIZE=10 at 0x11, SIZE=01 at 0x13, and SIZE=11 at 0x10 -> MISALIGN=1/1/0; memory unchanged in all three cases.
- Out of range: ADDR=DEPTH*4 with WE=1 -> no write; R_DATA=0. CPU WE=1 during LOAD -> dropped; R_DATA=0 while BUSY.
- RST asserted asynchronously mid-load after 2 words -> BUSY, LD_READY and LD_COUNT go to 0 immediately without a clock edge. After release, a fresh LD_START restarts at word 0; the 2 previously loaded words remain readable if no new load is issued.
